// File: rtl/step_seq_pkg.sv
// Shared types for the step sequencer: state encoding
// and step counter width.
package step_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam int STEP_W = 16;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-clk tick
// every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 600000
) (
  input  logic clk,
  input  logic rstInput,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rstInput) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/step_sequencer.sv
// Button-driven step sequencer: counts led up once per
// tick for N_STEPS ticks per run, with abort and repeat.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int LED_W    = 4,
  parameter int TICK_DIV = 600000,
  parameter int N_STEPS  = 8
) (
  input  logic             clk,
  input  logic             rstInput,
  input  logic             goInput,
  input  logic             abortInput,
  input  logic             modeRepeat,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             doneSig
);

  localparam logic [STEP_W-1:0] LAST_STEP =
    STEP_W'(N_STEPS - 1);

  logic goMeta;
  logic goS;
  logic abortMeta;
  logic abortS;
  logic tick;

  stateT state;
  stateT stateNext;

  logic [STEP_W-1:0] stepCnt;
  logic              lastStep;
  logic              ledInc;
  logic              runEntry;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) tickGen (
    .clk     (clk),
    .rstInput(rstInput),
    .tick    (tick)
  );

  // Button levels are asynchronous; two flops each.
  always_ff @(posedge clk) begin
    if (rstInput) begin
      goMeta    <= 1'b0;
      goS       <= 1'b0;
      abortMeta <= 1'b0;
      abortS    <= 1'b0;
    end else begin
      goMeta    <= goInput;
      goS       <= goMeta;
      abortMeta <= abortInput;
      abortS    <= abortMeta;
    end
  end

  always_ff @(posedge clk) begin
    if (rstInput) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  assign lastStep = (stepCnt == LAST_STEP);

  // Abort overrides everything, including a final-step tick.
  always_comb begin
    stateNext = state;
    if (abortS) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (tick && goS) begin
            stateNext = RUN;
          end
        end
        RUN: begin
          if (tick && lastStep) begin
            stateNext = DONE;
          end
        end
        DONE: begin
          if (tick && modeRepeat && goS) begin
            stateNext = RUN;
          end else if (tick && !goS) begin
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign ledInc   = (state == RUN) && tick && !abortS;
  assign runEntry = (state != RUN) && (stateNext == RUN);

  // led is never cleared on run entry, only by reset.
  always_ff @(posedge clk) begin
    if (rstInput) begin
      led     <= '0;
      stepCnt <= '0;
    end else begin
      if (runEntry) begin
        stepCnt <= '0;
      end else if (ledInc) begin
        stepCnt <= stepCnt + STEP_W'(1);
      end
      if (ledInc) begin
        led <= led + LED_W'(1);
      end
    end
  end

  always_comb begin
    busy    = (state == RUN);
    doneSig = (state == DONE);
  end

endmodule
